ifu_inst_queue: RTL and testbench

//  Instruction fetch queue between the IFU output (inst/addr/pred-branch/valid) and the ID stage.

---
 rtl/ifu_inst_queue_pkg.sv | 26 ++
 rtl/ifu_inst_queue_mem.sv | 26 ++
 rtl/ifu_inst_queue.sv | 117 +++++++++++
 tb/tb_ifu_inst_queue.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ifu_inst_queue_pkg.sv
// Shared types and helpers for the IFU instruction queue.
// Default widths apply unless INST_DATA_WIDTH / INST_ADDR_WIDTH come from defines.svh.
`ifndef INST_DATA_WIDTH
`define INST_DATA_WIDTH 32
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif

package ifu_inst_queue_pkg;

    localparam int unsigned IFQ_DEPTH = 4;
    localparam int unsigned PTR_W     = $clog2(IFQ_DEPTH) + 1;

    typedef struct packed {
        logic [`INST_DATA_WIDTH-1:0] inst;
        logic [`INST_ADDR_WIDTH-1:0] addr;
        logic                        pred_br;
        logic                        err;
    } ifq_entry_t;

    function automatic int unsigned ifq_free(input int unsigned depth, input int unsigned count);
        return depth - count;
    endfunction

endpackage

// File: rtl/ifu_inst_queue_mem.sv
// Storage array for the instruction queue: one write port, one asynchronous read port.
// The data array carries no reset; validity is tracked by the pointers in the top level.
module ifu_inst_queue_mem
    import ifu_inst_queue_pkg::*;
#(
    parameter int unsigned DEPTH = IFQ_DEPTH
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  ifq_entry_t               wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output ifq_entry_t               rdata_o
);

    ifq_entry_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            r_mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/ifu_inst_queue.sv
// Instruction fetch queue between the IFU and ID with registered almost-full stall request.
// Optional same-cycle bypass when empty is enabled by defining IFU_INST_QUEUE_BYPASS_EN.
module ifu_inst_queue
    import ifu_inst_queue_pkg::*;
#(
    parameter int unsigned DEPTH     = IFQ_DEPTH,
    parameter int unsigned AF_MARGIN = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic                         in_valid_i,
    input  logic [`INST_DATA_WIDTH-1:0]  in_inst_i,
    input  logic [`INST_ADDR_WIDTH-1:0]  in_addr_i,
    input  logic                         in_pred_br_i,
    input  logic                         in_err_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [`INST_DATA_WIDTH-1:0]  out_inst_o,
    output logic [`INST_ADDR_WIDTH-1:0]  out_addr_o,
    output logic                         out_pred_br_o,
    output logic                         out_err_o,
    output logic                         stall_req_o,
    output logic                         overflow_o,
    output logic [$clog2(DEPTH):0]       count_o
);

    localparam int unsigned PW = $clog2(DEPTH) + 1;
    localparam int unsigned AW = $clog2(DEPTH);

    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [PW-1:0] w_wr_ptr_d, w_rd_ptr_d;
    logic [PW-1:0] w_count, w_count_d;
    logic          r_stall, r_overflow;
    logic          w_stall_d, w_overflow_d;
    logic          w_empty, w_full;
    logic          w_push, w_pop_st, w_byp_take;
    logic          w_head_valid;
    ifq_entry_t    w_in_entry, w_rdata, w_head;

    assign w_in_entry = '{inst: in_inst_i, addr: in_addr_i, pred_br: in_pred_br_i,
                          err: in_err_i};

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_empty = (w_count == '0);
    assign w_full  = (w_count == PW'(DEPTH));

`ifdef IFU_INST_QUEUE_BYPASS_EN
    logic w_byp;
    // An empty queue forwards the incoming beat; it is only stored if ID stalls it.
    assign w_byp        = w_empty & in_valid_i & ~flush_i;
    assign w_byp_take   = w_byp & out_ready_i;
    assign w_head_valid = ~w_empty | w_byp;
    assign w_head       = w_empty ? w_in_entry : w_rdata;
`else
    assign w_byp_take   = 1'b0;
    assign w_head_valid = ~w_empty;
    assign w_head       = w_rdata;
`endif

    assign w_pop_st = ~w_empty & out_ready_i & ~flush_i;
    assign w_push   = in_valid_i & (~w_full | w_pop_st) & ~w_byp_take & ~flush_i;

    always_comb begin
        w_wr_ptr_d   = r_wr_ptr;
        w_rd_ptr_d   = r_rd_ptr;
        w_overflow_d = r_overflow;
        if (flush_i) begin
            w_wr_ptr_d = '0;
            w_rd_ptr_d = '0;
        end else begin
            w_wr_ptr_d = r_wr_ptr + {{(PW-1){1'b0}}, w_push};
            w_rd_ptr_d = r_rd_ptr + {{(PW-1){1'b0}}, w_pop_st};
            if (in_valid_i & w_full & ~w_pop_st) begin
                w_overflow_d = 1'b1;
            end
        end
        w_count_d = w_wr_ptr_d - w_rd_ptr_d;
        w_stall_d = ifq_free(DEPTH, {{(32-PW){1'b0}}, w_count_d}) <= AF_MARGIN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_stall    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_d;
            r_rd_ptr   <= w_rd_ptr_d;
            r_stall    <= w_stall_d;
            r_overflow <= w_overflow_d;
        end
    end

    ifu_inst_queue_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (w_push),
        .waddr_i (r_wr_ptr[AW-1:0]),
        .wdata_i (w_in_entry),
        .raddr_i (r_rd_ptr[AW-1:0]),
        .rdata_o (w_rdata)
    );

    // Zero-mask so ID never observes stale array contents.
    assign out_valid_o   = w_head_valid;
    assign out_inst_o    = w_head_valid ? w_head.inst : '0;
    assign out_addr_o    = w_head_valid ? w_head.addr : '0;
    assign out_pred_br_o = w_head_valid & w_head.pred_br;
    assign out_err_o     = w_head_valid & w_head.err;
    assign stall_req_o   = r_stall;
    assign overflow_o    = r_overflow;
    assign count_o       = w_count;

endmodule

// File: tb/tb_ifu_inst_queue.sv
// Directed self-checking bench for ifu_inst_queue (DEPTH=4, AF_MARGIN=2).
`ifndef INST_DATA_WIDTH
`define INST_DATA_WIDTH 32
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif

module tb_ifu_inst_queue;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        flush_i;
    logic                        in_valid_i;
    logic [`INST_DATA_WIDTH-1:0] in_inst_i;
    logic [`INST_ADDR_WIDTH-1:0] in_addr_i;
    logic                        in_pred_br_i;
    logic                        in_err_i;
    logic                        out_valid_o;
    logic                        out_ready_i;
    logic [`INST_DATA_WIDTH-1:0] out_inst_o;
    logic [`INST_ADDR_WIDTH-1:0] out_addr_o;
    logic                        out_pred_br_o;
    logic                        out_err_o;
    logic                        stall_req_o;
    logic                        overflow_o;
    logic [2:0]                  count_o;

    int checks = 0;
    int errors = 0;

    ifu_inst_queue #(
        .DEPTH     (4),
        .AF_MARGIN (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .in_valid_i    (in_valid_i),
        .in_inst_i     (in_inst_i),
        .in_addr_i     (in_addr_i),
        .in_pred_br_i  (in_pred_br_i),
        .in_err_i      (in_err_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_inst_o    (out_inst_o),
        .out_addr_o    (out_addr_o),
        .out_pred_br_o (out_pred_br_o),
        .out_err_o     (out_err_o),
        .stall_req_o   (stall_req_o),
        .overflow_o    (overflow_o),
        .count_o       (count_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid_i = 1'b1;
            in_inst_i  = 32'h0000_0013;
            in_addr_i  = 32'h8000_0000 + 32'(4 * i);
            step();
        end
        in_valid_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; in_inst_i = '0; in_addr_i = '0;
        in_pred_br_i = 1'b0; in_err_i = 1'b0; out_ready_i = 1'b0;

        // 1 reset
        step(); step();
        chk("rst_valid", out_valid_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_stall", stall_req_o, 0);
        chk("rst_ovf", overflow_o, 0);
        chk("rst_inst", out_inst_o, 0);
        rst = 1'b0;

        // 2 fill / drain
        for (int i = 0; i < 4; i++) begin
            in_valid_i = 1'b1;
            in_inst_i  = 32'h0000_0013;
            in_addr_i  = 32'h8000_0000 + 32'(4 * i);
            step();
            if (i == 0) chk("stall_after1", stall_req_o, 0);
            if (i == 1) chk("stall_after2", stall_req_o, 1);
        end
        in_valid_i = 1'b0;
        chk("fill_count", count_o, 4);
        chk("fill_stall", stall_req_o, 1);
        chk("fill_valid", out_valid_o, 1);
        out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_addr", out_addr_o, 32'h8000_0000 + 32'(4 * i));
            chk("drain_inst", out_inst_o, 32'h0000_0013);
            step();
        end
        out_ready_i = 1'b0;
        chk("drain_count", count_o, 0);
        chk("drain_valid", out_valid_o, 0);
        chk("drain_mask", out_inst_o, 0);
        chk("drain_stall", stall_req_o, 0);

        // 3 full + simultaneous push/pop
        fill(4);
        in_valid_i = 1'b1; in_inst_i = 32'hDEAD_BEEF; in_addr_i = 32'h8000_0010;
        out_ready_i = 1'b1;
        chk("pp_head", out_addr_o, 32'h8000_0000);
        step();
        in_valid_i = 1'b0;
        chk("pp_count", count_o, 4);
        chk("pp_ovf", overflow_o, 0);
        for (int i = 1; i <= 4; i++) begin
            chk("pp_addr", out_addr_o, 32'h8000_0000 + 32'(4 * i));
            if (i == 4) chk("pp_last_inst", out_inst_o, 32'hDEAD_BEEF);
            step();
        end
        out_ready_i = 1'b0;
        chk("pp_empty", count_o, 0);

        // 4 overflow, sticky across flush, cleared by reset
        fill(4);
        in_valid_i = 1'b1; in_inst_i = 32'hCAFE_BABE; in_addr_i = 32'h9000_0000;
        step();
        in_valid_i = 1'b0;
        chk("ovf_set", overflow_o, 1);
        chk("ovf_count", count_o, 4);
        chk("ovf_head", out_addr_o, 32'h8000_0000);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("ovf_flush_count", count_o, 0);
        chk("ovf_after_flush", overflow_o, 1);
        chk("ovf_flush_stall", stall_req_o, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("ovf_rst", overflow_o, 0);

        // 5 flush with concurrent push
        fill(3);
        chk("fl_count3", count_o, 3);
        flush_i = 1'b1; in_valid_i = 1'b1; in_inst_i = 32'h1111_1111; in_addr_i = 32'hA000_0000;
        step();
        flush_i = 1'b0; in_valid_i = 1'b0;
        chk("fl_count", count_o, 0);
        chk("fl_valid", out_valid_o, 0);
        step();
        chk("fl_valid2", out_valid_o, 0);
        chk("fl_inst2", out_inst_o, 0);

        // 6 pointer wrap with flags on the 7th entry
        for (int i = 0; i < 10; i++) begin
            in_valid_i   = 1'b1;
            in_inst_i    = 32'h100 + 32'(i);
            in_addr_i    = 32'h8000_1000 + 32'(4 * i);
            in_pred_br_i = (i == 6);
            in_err_i     = (i == 6);
            out_ready_i  = 1'b0;
            step();
            in_valid_i = 1'b0; in_pred_br_i = 1'b0; in_err_i = 1'b0;
            chk("wr_valid", out_valid_o, 1);
            chk("wr_inst", out_inst_o, 32'h100 + 32'(i));
            chk("wr_pred", out_pred_br_o, (i == 6) ? 1 : 0);
            chk("wr_err", out_err_o, (i == 6) ? 1 : 0);
            out_ready_i = 1'b1;
            step();
            out_ready_i = 1'b0;
        end
        chk("wr_count", count_o, 0);

`ifdef IFU_INST_QUEUE_BYPASS_EN
        in_valid_i = 1'b1; in_inst_i = 32'h0BAD_F00D; in_addr_i = 32'hB000_0000;
        out_ready_i = 1'b1;
        #1;
        chk("byp_valid", out_valid_o, 1);
        chk("byp_inst", out_inst_o, 32'h0BAD_F00D);
        step();
        in_valid_i = 1'b0; out_ready_i = 1'b0;
        chk("byp_count", count_o, 0);
        chk("byp_after", out_valid_o, 0);
`else
        in_valid_i = 1'b1; in_inst_i = 32'h0BAD_F00D; in_addr_i = 32'hB000_0000;
        out_ready_i = 1'b1;
        #1;
        chk("nobyp_valid", out_valid_o, 0);
        step();
        in_valid_i = 1'b0; out_ready_i = 1'b0;
        chk("nobyp_count", count_o, 1);
        chk("nobyp_inst", out_inst_o, 32'h0BAD_F00D);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
